// File: rtl/vm_pkg.sv
// vm_pkg: shared types and constants for the vending-machine transaction
// scheduler and its inventory register file.
//   - state_e : scheduler FSM states
//   - req_e   : requester identity used for round-robin tie breaking
//   - COIN_*  : coin input encodings and their values in cents
//   - STAT_*  : status output codes
package vm_pkg;

  // Width of an item index (supplier item select, latched consumer item).
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SUP_WRITE  = 2'd1,
    ST_CON_SELECT = 2'd2,
    ST_CON_VEND   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_SUPPLIER = 1'b0,
    REQ_CONSUMER = 1'b1
  } req_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  localparam logic [4:0] COIN_VAL_5  = 5'd5;
  localparam logic [4:0] COIN_VAL_10 = 5'd10;
  localparam logic [4:0] COIN_VAL_25 = 5'd25;

  localparam logic [1:0] STAT_ERROR   = 2'b00;
  localparam logic [1:0] STAT_UNAVAIL = 2'b01;
  localparam logic [1:0] STAT_PROC    = 2'b10;
  localparam logic [1:0] STAT_VENDED  = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] c);
    logic [4:0] v;
    case (c)
      COIN_5:  v = COIN_VAL_5;
      COIN_10: v = COIN_VAL_10;
      COIN_25: v = COIN_VAL_25;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_inventory.sv
// vm_inventory: NUM_ITEMS x {count, cost} register file.
//   clk, rst         : clock, synchronous active-high clear of all entries
//   i_we             : write enable (supplier write or purchase decrement)
//   i_widx           : write index (ignored when out of range)
//   i_wcount/i_wcost : write data
//   i_ridx           : combinational read index (reads 0 when out of range)
//   o_rcount/o_rcost : read data
module vm_inventory
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 6,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned COST_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [CNT_W-1:0]  i_wcount,
  input  logic [COST_W-1:0] i_wcost,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [CNT_W-1:0]  o_rcount,
  output logic [COST_W-1:0] o_rcost
);

  localparam logic [IDX_W:0] LP_NUM = (IDX_W+1)'(NUM_ITEMS);

  logic [CNT_W-1:0]  r_count [NUM_ITEMS];
  logic [COST_W-1:0] r_cost  [NUM_ITEMS];

  logic w_wr_in_range;
  logic w_rd_in_range;

  assign w_wr_in_range = ({1'b0, i_widx} < LP_NUM);
  assign w_rd_in_range = ({1'b0, i_ridx} < LP_NUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        r_count[i] <= '0;
        r_cost[i]  <= '0;
      end
    end else if (i_we && w_wr_in_range) begin
      r_count[i_widx] <= i_wcount;
      r_cost[i_widx]  <= i_wcost;
    end
  end

  always_comb begin
    o_rcount = '0;
    o_rcost  = '0;
    if (w_rd_in_range) begin
      o_rcount = r_count[i_ridx];
      o_rcost  = r_cost[i_ridx];
    end
  end

endmodule

// File: rtl/vm_txn_scheduler.sv
// vm_txn_scheduler: single owner of the vending machine inventory/price table
// and credit register. Arbitrates supplier writes against consumer purchase
// transactions, locks the table for a whole consumer transaction and aborts
// a transaction that stays idle for TIMEOUT cycles.
//   clk, rst                      : clock, synchronous active-high reset
//   sup_req/sup_item/sup_count/
//   sup_cost, sup_gnt             : supplier write request and grant pulse
//   button, coins, enter_key,
//   soft_rst                      : consumer panel inputs
//   con_gnt                       : consumer transaction owns the table
//   product, vend                 : vend actuator (item+1, one-cycle strobe)
//   status, status_vld, balance,
//   info                          : consumer display outputs
// All outputs are registered.
module vm_txn_scheduler
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 6,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned COST_W    = 8,
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sup_req,
  input  logic [2:0]           sup_item,
  input  logic [CNT_W-1:0]     sup_count,
  input  logic [COST_W-1:0]    sup_cost,
  output logic                 sup_gnt,
  input  logic [NUM_ITEMS-1:0] button,
  input  logic [1:0]           coins,
  input  logic                 enter_key,
  input  logic                 soft_rst,
  output logic                 con_gnt,
  output logic [2:0]           product,
  output logic                 vend,
  output logic [1:0]           status,
  output logic                 status_vld,
  output logic [BAL_W-1:0]     balance,
  output logic [COST_W-1:0]    info
);

  localparam int unsigned    TMO_W  = $clog2(TIMEOUT);
  localparam logic [IDX_W:0] LP_NUM = (IDX_W+1)'(NUM_ITEMS);

  state_e             r_state, w_state_nxt;
  req_e               r_last_gnt, w_last_gnt_nxt;
  logic [IDX_W-1:0]   r_item, w_item_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [BAL_W-1:0]   r_balance, w_balance_nxt;
  logic               r_sup_gnt, w_sup_gnt_nxt;
  logic               r_con_gnt, w_con_gnt_nxt;
  logic [2:0]         r_product, w_product_nxt;
  logic               r_vend, w_vend_nxt;
  logic [1:0]         r_status, w_status_nxt;
  logic               r_status_vld, w_status_vld_nxt;
  logic [COST_W-1:0]  r_info, w_info_nxt;

  logic               w_btn_ok;
  logic [IDX_W-1:0]   w_btn_idx;
  logic [BAL_W:0]     w_bal_sum;
  logic [BAL_W-1:0]   w_bal_cred;
  logic               w_sup_in_range;
  logic               w_activity;
  logic               w_grant_sup;
  logic               w_grant_con;

  logic               w_inv_we;
  logic [IDX_W-1:0]   w_inv_widx;
  logic [CNT_W-1:0]   w_inv_wcount;
  logic [COST_W-1:0]  w_inv_wcost;
  logic [IDX_W-1:0]   w_inv_ridx;
  logic [CNT_W-1:0]   w_rd_count;
  logic [COST_W-1:0]  w_rd_cost;

  vm_inventory #(
    .NUM_ITEMS (NUM_ITEMS),
    .CNT_W     (CNT_W),
    .COST_W    (COST_W)
  ) u_inv (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_inv_we),
    .i_widx   (w_inv_widx),
    .i_wcount (w_inv_wcount),
    .i_wcost  (w_inv_wcost),
    .i_ridx   (w_inv_ridx),
    .o_rcount (w_rd_count),
    .o_rcost  (w_rd_cost)
  );

  assign w_btn_ok = (button != '0) &&
                    ((button & (button - NUM_ITEMS'(1))) == '0);

  always_comb begin
    w_btn_idx = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (button[i]) w_btn_idx = IDX_W'(i);
    end
  end

  // Coin credit saturates at all-ones rather than wrapping.
  assign w_bal_sum  = {1'b0, r_balance} + (BAL_W+1)'(coin_value(coins));
  assign w_bal_cred = w_bal_sum[BAL_W] ? '1 : w_bal_sum[BAL_W-1:0];

  assign w_sup_in_range = ({1'b0, sup_item} < LP_NUM);
  assign w_activity     = (coins != COIN_NONE) || enter_key || soft_rst;

  // Ties go to the side that was not granted last.
  assign w_grant_sup = sup_req && (!w_btn_ok || (r_last_gnt == REQ_CONSUMER));
  assign w_grant_con = w_btn_ok && !w_grant_sup;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_gnt_nxt   = r_last_gnt;
    w_item_nxt       = r_item;
    w_tmo_nxt        = r_tmo;
    w_balance_nxt    = r_balance;
    w_sup_gnt_nxt    = 1'b0;
    w_con_gnt_nxt    = 1'b0;
    w_product_nxt    = '0;
    w_vend_nxt       = 1'b0;
    w_status_nxt     = r_status;
    w_status_vld_nxt = 1'b0;
    w_info_nxt       = r_info;
    w_inv_we         = 1'b0;
    w_inv_widx       = sup_item;
    w_inv_wcount     = sup_count;
    w_inv_wcost      = sup_cost;
    w_inv_ridx       = r_item;

    case (r_state)
      ST_IDLE: begin
        w_inv_ridx    = w_btn_idx;
        w_balance_nxt = w_bal_cred;
        if (w_grant_sup) begin
          w_state_nxt    = ST_SUP_WRITE;
          w_sup_gnt_nxt  = 1'b1;
          w_last_gnt_nxt = REQ_SUPPLIER;
          if (!w_sup_in_range) begin
            w_status_nxt     = STAT_ERROR;
            w_status_vld_nxt = 1'b1;
            w_info_nxt       = '0;
          end
        end else if (w_grant_con) begin
          w_state_nxt      = ST_CON_SELECT;
          w_last_gnt_nxt   = REQ_CONSUMER;
          w_item_nxt       = w_btn_idx;
          w_tmo_nxt        = '0;
          w_con_gnt_nxt    = 1'b1;
          w_info_nxt       = w_rd_cost;
          w_status_nxt     = STAT_PROC;
          w_status_vld_nxt = 1'b1;
        end else if (button != '0) begin
          w_status_nxt     = STAT_ERROR;
          w_status_vld_nxt = 1'b1;
          w_info_nxt       = '0;
        end
      end

      ST_SUP_WRITE: begin
        // sup_gnt was raised on entry; data is committed as the grant ends.
        w_state_nxt = ST_IDLE;
        w_inv_we    = w_sup_in_range;
      end

      ST_CON_SELECT: begin
        w_balance_nxt    = w_bal_cred;
        w_con_gnt_nxt    = 1'b1;
        w_status_vld_nxt = 1'b1;
        w_tmo_nxt        = w_activity ? '0 : r_tmo + TMO_W'(1);
        if (soft_rst) begin
          w_state_nxt   = ST_IDLE;
          w_con_gnt_nxt = 1'b0;
          w_status_nxt  = STAT_UNAVAIL;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_con_gnt_nxt = 1'b0;
          w_status_nxt  = STAT_ERROR;
          w_info_nxt    = '0;
        end else if (enter_key) begin
          if (w_rd_count == '0) begin
            w_state_nxt   = ST_IDLE;
            w_con_gnt_nxt = 1'b0;
            w_status_nxt  = STAT_UNAVAIL;
          end else if (r_balance >= BAL_W'(w_rd_cost)) begin
            // Debit and decrement are committed on entry to CON_VEND so the
            // updated balance is visible alongside the vend strobe.
            w_state_nxt   = ST_CON_VEND;
            w_inv_we      = 1'b1;
            w_inv_widx    = r_item;
            w_inv_wcount  = w_rd_count - CNT_W'(1);
            w_inv_wcost   = w_rd_cost;
            w_balance_nxt = w_bal_cred - BAL_W'(w_rd_cost);
            w_vend_nxt    = 1'b1;
            w_product_nxt = r_item + IDX_W'(1);
            w_status_nxt  = STAT_VENDED;
          end else begin
            w_status_nxt = STAT_UNAVAIL;
          end
        end
      end

      ST_CON_VEND: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_gnt   <= REQ_CONSUMER;
      r_item       <= '0;
      r_tmo        <= '0;
      r_balance    <= '0;
      r_sup_gnt    <= 1'b0;
      r_con_gnt    <= 1'b0;
      r_product    <= '0;
      r_vend       <= 1'b0;
      r_status     <= STAT_ERROR;
      r_status_vld <= 1'b0;
      r_info       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_gnt   <= w_last_gnt_nxt;
      r_item       <= w_item_nxt;
      r_tmo        <= w_tmo_nxt;
      r_balance    <= w_balance_nxt;
      r_sup_gnt    <= w_sup_gnt_nxt;
      r_con_gnt    <= w_con_gnt_nxt;
      r_product    <= w_product_nxt;
      r_vend       <= w_vend_nxt;
      r_status     <= w_status_nxt;
      r_status_vld <= w_status_vld_nxt;
      r_info       <= w_info_nxt;
    end
  end

  assign sup_gnt    = r_sup_gnt;
  assign con_gnt    = r_con_gnt;
  assign product    = r_product;
  assign vend       = r_vend;
  assign status     = r_status;
  assign status_vld = r_status_vld;
  assign balance    = r_balance;
  assign info       = r_info;

endmodule

// File: doc/vm_txn_scheduler.md
Name: vm_txn_scheduler

Overview:
- Sequences all access to the vending machine's shared inventory/price table and credit register.
- Arbitrates between two requesters: supplier restock/price writes and consumer purchase transactions.
- Holds a lock for the full duration of a consumer transaction and aborts stalled transactions on timeout.
- Sits between the supplier/consumer front panels and the vend actuator; it is the single owner of inventory state.

Parameters:
- NUM_ITEMS, 6, number of item slots (button width).
- CNT_W, 4, per-item count width.
- COST_W, 8, per-item cost width (cents).
- BAL_W, 16, credit/balance width (cents).
- TIMEOUT, 64, idle cycles in a transaction before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- sup_req  in  1  supplier write request; held until sup_gnt.
- sup_item  in  3  supplier item index.
- sup_count  in  CNT_W  new count.
- sup_cost  in  COST_W  new cost.
- sup_gnt  out  1  one-cycle pulse; write performed this cycle.
- button  in  NUM_ITEMS  consumer item select; must be one-hot.
- coins  in  2  01=5c, 10=10c, 11=25c, 00=none.
- enter_key  in  1  consumer purchase confirm.
- soft_rst  in  1  consumer cancel.
- con_gnt  out  1  high while a consumer transaction owns the table.
- product  out  3  item+1 on vend, else 0.
- vend  out  1  one-cycle vend strobe.
- status  out  2  00 error, 01 unavailable/insufficient, 10 processing, 11 vended.
- status_vld  out  1  status meaningful.
- balance  out  BAL_W  current credit.
- info  out  COST_W  cost of selected item; 0 on error.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, table cleared (all counts/costs 0), balance=0.
  - product=0, vend=0, sup_gnt=0, con_gnt=0, status=00, status_vld=0, info=0.
  - last_gnt=CONSUMER, so the supplier wins the first tie.
  - rst overrides every state, including a transaction in progress.
- States: IDLE, SUP_WRITE, CON_SELECT, CON_VEND.
- IDLE:
  - btn_ok = button one-hot.
  - Supplier and btn_ok both asserted: grant the side opposite last_gnt.
  - Otherwise grant whichever side requests.
  - Supplier grant -> SUP_WRITE.
  - Consumer grant -> CON_SELECT: latch item index, info=cost[item], status=10, status_vld=1.
  - button nonzero but not one-hot: stay IDLE, status=00, info=0, status_vld=1 for one cycle.
  - Coins are accepted in IDLE and CON_SELECT only.
- SUP_WRITE (1 cycle):
  - sup_gnt=1, last_gnt=SUPPLIER -> IDLE.
  - sup_item<NUM_ITEMS: table[sup_item] <= {sup_count, sup_cost}.
  - Otherwise: no write, status=00.
- CON_SELECT:
  - con_gnt=1; sup_req stays pending (sup_gnt=0); last_gnt=CONSUMER.
  - Idle counter clears on any coin, enter_key or soft_rst, and increments otherwise.
  - Evaluated in priority order:
    1. soft_rst -> IDLE, status=01, balance kept.
    2. Counter == TIMEOUT-1 -> IDLE, status=00, balance kept.
    3. enter_key && count[item]==0 -> IDLE, status=01.
    4. enter_key && balance >= cost -> CON_VEND.
    5. enter_key && balance < cost -> stay, status=01.
  - Enter comparison uses the registered balance (pre-coin); a same-cycle coin is still credited.
- CON_VEND (1 cycle):
  - count[item]--, balance -= cost.
  - product=item+1, vend=1, status=11 -> IDLE.
  - product and vend return to 0 the next cycle.
- Arithmetic:
  - Coin addition saturates at all-ones BAL_W.
  - Count decrement is never reached at 0 (guarded in CON_SELECT).
  - Cost 0 is legal and vends with no credit.
- Output timing: all outputs registered; status/info hold their last value until the next update.

Decomposition:
- Package vm_pkg:
  - state enum.
  - coin encoding and coin value constants (5/10/25).
  - status code constants.
  - requester enum {SUPPLIER, CONSUMER}.
- Sub-module vm_inventory:
  - NUM_ITEMS x {count, cost} register file.
  - One write port (supplier write or decrement, mutually exclusive by state).
  - Combinational read by index; synchronous clear on rst.

Test Plan:
1. Restock: rst, then sup_req item2 count3 cost 25 -> sup_gnt pulse one cycle later; button=000100, enter_key with 0 credit -> info=25, status=01, no vend.
2. Purchase: 10c+10c+5c coins, enter_key -> next cycle vend=1, product=3, status=11, balance=0, item2 count=2.
3. Tie and lock: sup_req and button=000001 same cycle after reset -> supplier first, consumer next. sup_req raised during CON_SELECT -> sup_gnt only after return to IDLE.
4. Error paths:
   - button=000011 -> status=00, info=0, stays IDLE.
   - Purchase of a count-0 item -> status=01.
   - sup_item=7 -> sup_gnt with no table change, status=00.
5. Timeout and cancel:
   - Select item, no activity for 64 cycles -> IDLE, status=00, balance kept.
   - soft_rst mid-transaction -> IDLE, status=01.
6. Reset mid-CON_SELECT with balance 35 -> all outputs and table cleared, state IDLE.
